// File: rtl/qmfir_uart_burst_proto.sv
// UART command-protocol engine: byte frames -> burst reg/mem reads and writes.
// Optional write ACK byte (8'h5A) when QMFIR_UARTP_ACK_EN is defined.
module qmfir_uart_burst_proto #(
  parameter int ADDR_W      = 14,
  parameter int DATA_BYTES  = 3,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_empty,
  output logic                    rx_re,
  output logic [7:0]              tx_data,
  input  logic                    tx_full,
  output logic                    tx_we,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  output logic                    mem_we,
  output logic                    reg_we,
  output logic                    mem_re,
  output logic                    reg_re,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  output logic                    busy,
  output logic                    err_tmo
);

  localparam int HB = (ADDR_W + 2 + 7) / 8;
  localparam int HW = 8 * HB;
  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_WDATA,
    S_WCOMMIT,
    S_RREQ,
    S_RWAIT,
    S_RSEND,
    S_DONE
`ifdef QMFIR_UARTP_ACK_EN
    , S_ACK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [HW-1:0]     hdr_q, hdr_d;
  logic              w_q, w_d;
  logic              mem_q, mem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rsh_q, rsh_d;
  logic [8:0]        rem_q, rem_d;
  logic [15:0]       lat_q, lat_d;
  logic [15:0]       tmo_q, tmo_d;

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    hdr_d   = hdr_q;
    w_d     = w_q;
    mem_d   = mem_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsh_d   = rsh_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    tmo_d   = '0;
    rx_re   = 1'b0;
    tx_we   = 1'b0;
    tx_data = rsh_q[DW-1 -: 8];
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    mem_re  = 1'b0;
    reg_re  = 1'b0;
    err_tmo = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (!rx_empty) state_d = S_HDR;
      end
      S_HDR: if (!rx_empty) begin
        rx_re  = 1'b1;
        hdr_d  = HW'({hdr_q, rx_data});
        bcnt_d = bcnt_q + 8'd1;
        if (bcnt_q == 8'(HB - 1)) begin
          bcnt_d  = '0;
          w_d     = hdr_d[HW-1];
          mem_d   = hdr_d[HW-2];
          addr_d  = hdr_d[ADDR_W-1:0];
          state_d = S_LEN;
        end
      end
      S_LEN: if (!rx_empty) begin
        rx_re   = 1'b1;
        rem_d   = {1'b0, rx_data} + 9'd1;
        state_d = w_q ? S_WDATA : S_RREQ;
      end
      S_WDATA: if (!rx_empty) begin
        rx_re   = 1'b1;
        wdata_d = DW'({wdata_q, rx_data});
        bcnt_d  = bcnt_q + 8'd1;
        if (bcnt_q == 8'(DATA_BYTES - 1)) begin
          bcnt_d  = '0;
          state_d = S_WCOMMIT;
        end
      end
      S_WCOMMIT: begin
        mem_we  = mem_q;
        reg_we  = ~mem_q;
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - 9'd1;
        state_d = (rem_q == 9'd1) ? S_DONE : S_WDATA;
      end
      S_RREQ: begin
        mem_re  = mem_q;
        reg_re  = ~mem_q;
        addr_d  = addr_q + ADDR_W'(1);
        lat_d   = '0;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        lat_d = lat_q + 16'd1;
        if (lat_q == 16'(RD_LAT - 1)) begin
          rsh_d   = mem_q ? mem_rdata : reg_rdata;
          bcnt_d  = '0;
          state_d = S_RSEND;
        end
      end
      S_RSEND: if (!tx_full) begin
        tx_we  = 1'b1;
        rsh_d  = rsh_q << 8;
        bcnt_d = bcnt_q + 8'd1;
        if (bcnt_q == 8'(DATA_BYTES - 1)) begin
          bcnt_d  = '0;
          rem_d   = rem_q - 9'd1;
          state_d = (rem_q == 9'd1) ? S_DONE : S_RREQ;
        end
      end
      S_DONE: begin
`ifdef QMFIR_UARTP_ACK_EN
        state_d = w_q ? S_ACK : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef QMFIR_UARTP_ACK_EN
      S_ACK: begin
        tx_data = 8'h5A;
        if (!tx_full) begin
          tx_we   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Starvation only aborts while a frame is still being received
    if ((state_q == S_HDR || state_q == S_LEN || state_q == S_WDATA) && rx_empty) begin
      tmo_d = tmo_q + 16'd1;
      if (TIMEOUT_CYC != 0 && tmo_q == 16'(TIMEOUT_CYC - 1)) begin
        err_tmo = 1'b1;
        tmo_d   = '0;
        state_d = S_IDLE;
      end
    end

    if (rst) begin
      rx_re   = 1'b0;
      tx_we   = 1'b0;
      mem_we  = 1'b0;
      reg_we  = 1'b0;
      mem_re  = 1'b0;
      reg_re  = 1'b0;
      err_tmo = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      hdr_q   <= '0;
      w_q     <= 1'b0;
      mem_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsh_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      hdr_q   <= hdr_d;
      w_q     <= w_d;
      mem_q   <= mem_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsh_q   <= rsh_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_qmfir_uart_burst_proto.sv
// Scoreboard bench for qmfir_uart_burst_proto (ADDR_W=14, 3-byte words).
// Strobes and TX bytes are queued as frames are sent and popped on output.
module tb_qmfir_uart_burst_proto;

  localparam int AW  = 14;
  localparam int DW  = 24;
  localparam int RL  = 1;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic          rx_re;
  logic [7:0]    tx_data;
  logic          tx_full = 1'b0;
  logic          tx_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          mem_we, reg_we, mem_re, reg_re;
  logic [DW-1:0] mrd = '0;
  logic [DW-1:0] rrd = '0;
  logic          busy;
  logic          err_tmo;

  always #5 clk = ~clk;

  qmfir_uart_burst_proto #(
    .ADDR_W(AW), .DATA_BYTES(3), .RD_LAT(RL), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_re(rx_re),
    .tx_data(tx_data), .tx_full(tx_full), .tx_we(tx_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .mem_we(mem_we), .reg_we(reg_we),
    .mem_re(mem_re), .reg_re(reg_re),
    .mem_rdata(mrd), .reg_rdata(rrd),
    .busy(busy), .err_tmo(err_tmo)
  );

  logic [7:0] rxmem [1024];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int cyc = 0;
  assign rx_empty = (rd_ptr == wr_ptr);
  assign rx_data  = rxmem[rd_ptr[9:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_re) rd_ptr <= rd_ptr + 1;
    if (mem_re) mrd <= DW'(bus_addr) + 24'd1;
    if (reg_re) rrd <= DW'(bus_addr) ^ 24'hA5A5A5;
  end

  typedef struct packed {
    logic [1:0]    k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } sb_t;

  sb_t        sbq[$];
  logic [7:0] txq[$];
  int n_chk  = 0;
  int n_fail = 0;
  int tx_cnt = 0;
  int rd_cyc = 0;
  bit lat_pend = 0;
  bit check_lat = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    rxmem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  task automatic exp_strb(input logic [1:0] kk, input logic [AW-1:0] aa, input logic [DW-1:0] dd);
    sbq.push_back(sb_t'{kk, aa, dd});
  endtask

  task automatic exp_word(input logic [DW-1:0] w);
    txq.push_back(w[23:16]);
    txq.push_back(w[15:8]);
    txq.push_back(w[7:0]);
  endtask

  task automatic exp_ack;
`ifdef QMFIR_UARTP_ACK_EN
    txq.push_back(8'h5A);
`endif
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && rd_ptr == wr_ptr && txq.size() == 0 && sbq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  always @(negedge clk) begin
    logic [1:0] k;
    int ns;
    sb_t e;
    if (rx_re) chk("rx_re_empty", 64'(rx_empty), 64'd0);
    if (mem_we | reg_we | mem_re | reg_re) begin
      ns = int'(mem_we) + int'(reg_we) + int'(mem_re) + int'(reg_re);
      chk("strb_onehot", 64'(ns), 64'd1);
      k = {mem_re | reg_re, mem_we | mem_re};
      if (sbq.size() == 0) chk("strb_unexp", 64'(sbq.size()), 64'd1);
      else begin
        e = sbq.pop_front();
        chk("strb_kind", 64'(k), 64'(e.k));
        chk("strb_addr", 64'(bus_addr), 64'(e.a));
        if (!k[1]) chk("strb_wdata", 64'(bus_wdata), 64'(e.d));
      end
      if (k[1]) begin
        rd_cyc = cyc;
        lat_pend = 1;
      end
    end
    if (tx_we) begin
      tx_cnt++;
      chk("tx_when_full", 64'(tx_full), 64'd0);
      if (txq.size() == 0) chk("tx_unexp", 64'(txq.size()), 64'd1);
      else chk("tx_byte", 64'(tx_data), 64'(txq.pop_front()));
      if (lat_pend && check_lat) chk("rd_lat", 64'(cyc - rd_cyc), 64'(RL + 1));
      lat_pend = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bit got;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_wdata", 64'(bus_wdata), 64'd0);
    chk("rst_txd", 64'(tx_data), 64'd0);
    chk("rst_strb", 64'({tx_we, rx_re, mem_we, reg_we, mem_re, reg_re, err_tmo}), 64'd0);
    tick;
    rst = 1'b0;

    // reg write, single word
    tick;
    put(8'h80); put(8'h05); put(8'h00); put(8'h12); put(8'h34); put(8'h56);
    exp_strb(2'd0, 14'h0005, 24'h123456);
    exp_ack;
    drain("t1_done");

    // mem read burst of 3 with rdata = addr+1
    check_lat = 1;
    tick;
    put(8'h40); put(8'h10); put(8'h02);
    for (int i = 0; i < 3; i++) begin
      exp_strb(2'd3, AW'(14'h10 + i), '0);
      exp_word(DW'(24'h11 + i));
    end
    drain("t2_done");
    check_lat = 0;

    // mem write burst across address wrap
    tick;
    put(8'hFF); put(8'hFF); put(8'h01);
    put(8'h00); put(8'h00); put(8'h01);
    put(8'h00); put(8'h00); put(8'h02);
    exp_strb(2'd1, 14'h3FFF, 24'h000001);
    exp_strb(2'd1, 14'h0000, 24'h000002);
    exp_ack;
    drain("t3_done");

    // starve mid-word: abort on 16th empty cycle
    tick;
    put(8'h80); put(8'h05); put(8'h00); put(8'h12);
    n = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_ptr == wr_ptr) n++;
      if (err_tmo) begin
        got = 1;
        break;
      end
    end
    chk("tmo_seen", 64'(got), 64'd1);
    chk("tmo_cycle", 64'(n), 64'(TMO));
    @(negedge clk);
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_pulse", 64'(err_tmo), 64'd0);
    tick;
    put(8'h80); put(8'h05); put(8'h00); put(8'h12); put(8'h34); put(8'h56);
    exp_strb(2'd0, 14'h0005, 24'h123456);
    exp_ack;
    drain("t4_recover");

    // TX backpressure during a 2-word reg read
    tick;
    tx_full = 1'b1;
    put(8'h00); put(8'h20); put(8'h01);
    for (int i = 0; i < 2; i++) begin
      exp_strb(2'd2, AW'(14'h20 + i), '0);
      exp_word(DW'(24'h20 + i) ^ 24'hA5A5A5);
    end
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_we) n++;
    end
    chk("full_hold_tx", 64'(n), 64'd0);
    chk("full_hold_busy", 64'(busy), 64'd1);
    tick;
    tx_full = 1'b0;
    drain("t5_full_done");

    // reset in the middle of a 6-word mem read
    tick;
    put(8'h40); put(8'h30); put(8'h05);
    for (int i = 0; i < 6; i++) begin
      exp_strb(2'd3, AW'(14'h30 + i), '0);
      exp_word(DW'(24'h31 + i));
    end
    base = tx_cnt;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_cnt - base >= 4) break;
    end
    chk("rst_pre_tx", 64'(tx_cnt - base >= 4), 64'd1);
    tick;
    rst = 1'b1;
    txq.delete();
    sbq.delete();
    @(negedge clk);
    chk("rst_gate", 64'({tx_we, mem_re, reg_re, mem_we, reg_we}), 64'd0);
    tick;
    @(negedge clk);
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_addr", 64'(bus_addr), 64'd0);
    chk("rmid_wdata", 64'(bus_wdata), 64'd0);
    chk("rmid_txd", 64'(tx_data), 64'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rpost_busy", 64'(busy), 64'd0);
    chk("rpost_out", 64'({tx_we, rx_re, mem_re, err_tmo}), 64'd0);

    // recovery: reg write then reg read (read must not ACK)
    tick;
    put(8'h80); put(8'h07); put(8'h00); put(8'hAB); put(8'hCD); put(8'hEF);
    exp_strb(2'd0, 14'h0007, 24'hABCDEF);
    exp_ack;
    drain("t6_write");
    tick;
    put(8'h00); put(8'h07); put(8'h00);
    exp_strb(2'd2, 14'h0007, '0);
    exp_word(24'h000007 ^ 24'hA5A5A5);
    drain("t6_read");

    repeat (5) @(negedge clk);
    chk("txq_left", 64'(txq.size()), 64'd0);
    chk("sbq_left", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
